// File: rtl/sobel_frame_sequencer_if.sv
// Bus bundle between the frame sequencer, the source pixel memory, the
// stochastic Sobel core and the dense edge memory.
interface sobel_frame_sequencer_if #(
    parameter int ADDR_W = 20
);
    // Strobe protocol: src_rd/src_addr return src_rdata exactly one cycle later,
    // core_start is a one-cycle pulse answered by a core_done rising edge with
    // core_z valid on that edge, and edge_we is a one-cycle write strobe that
    // qualifies edge_addr/edge_wdata. There is no back-pressure on any path.
    logic [ADDR_W-1:0] src_addr;
    logic              src_rd;
    logic [7:0]        src_rdata;

    logic [7:0] pixel_1_bin;
    logic [7:0] pixel_2_bin;
    logic [7:0] pixel_3_bin;
    logic [7:0] pixel_4_bin;
    logic [7:0] pixel_6_bin;
    logic [7:0] pixel_7_bin;
    logic [7:0] pixel_8_bin;
    logic [7:0] pixel_9_bin;
    logic       core_start;
    logic       core_done;
    logic [7:0] core_z;

    logic              edge_we;
    logic [ADDR_W-1:0] edge_addr;
    logic [7:0]        edge_wdata;

    modport master (
        output src_addr, src_rd,
        input  src_rdata,
        output pixel_1_bin, pixel_2_bin, pixel_3_bin, pixel_4_bin,
        output pixel_6_bin, pixel_7_bin, pixel_8_bin, pixel_9_bin,
        output core_start,
        input  core_done, core_z,
        output edge_we, edge_addr, edge_wdata
    );

    modport slave (
        input  src_addr, src_rd,
        output src_rdata,
        input  pixel_1_bin, pixel_2_bin, pixel_3_bin, pixel_4_bin,
        input  pixel_6_bin, pixel_7_bin, pixel_8_bin, pixel_9_bin,
        input  core_start,
        output core_done, core_z,
        input  edge_we, edge_addr, edge_wdata
    );
endinterface

// File: rtl/sobel_frame_sequencer.sv
// Scans every 3x3 window of a source image through the stochastic Sobel core
// and writes each result to a dense edge memory. Optional: SEQ_WINDOW_REUSE_EN.
module sobel_frame_sequencer #(
    parameter int SRC_ROWS = 3,
    parameter int SRC_COLS = 3,
    parameter int ADDR_W   = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] dbg_state,
    sobel_frame_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_WRITE, S_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(SRC_COLS);
    localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(SRC_ROWS - 2);
    localparam logic [ADDR_W-1:0] LAST_J = ADDR_W'(SRC_COLS - 2);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] i_q, j_q, eaddr_q;
    logic [3:0]        cnt_q;
    logic [7:0]        win [9];
    logic              rd_q;
    logic [3:0]        rd_slot_q;
    logic              done_q;
    logic [7:0]        z_q;

    logic [3:0]        fetch_len, rd_slot;
    logic [ADDR_W-1:0] base_addr, rd_addr;
    logic              done_rise, last_win;
    logic              src_rd, core_start, edge_we;

`ifdef SEQ_WINDOW_REUSE_EN
    // First window of a row loads all nine pixels; later ones only the new right column.
    assign fetch_len = (j_q == ONE_A) ? 4'd9 : 4'd3;
    assign rd_slot   = (j_q == ONE_A) ? cnt_q : cnt_q * 4'd3 + 4'd2;
`else
    assign fetch_len = 4'd8;
    assign rd_slot   = (cnt_q < 4'd4) ? cnt_q : cnt_q + 4'd1;
`endif

    assign base_addr = (i_q - ONE_A) * COLS_A + (j_q - ONE_A);
    assign rd_addr   = base_addr + ADDR_W'(rd_slot / 4'd3) * COLS_A + ADDR_W'(rd_slot % 4'd3);
    assign done_rise = bus.core_done & ~done_q;
    assign last_win  = (i_q == LAST_I) && (j_q == LAST_J);

    always_comb begin
        state_nx   = state;
        src_rd     = 1'b0;
        core_start = 1'b0;
        edge_we    = 1'b0;
        case (state)
            S_IDLE:   if (frame_start) state_nx = S_FETCH;
            S_FETCH: begin
                src_rd = (cnt_q < fetch_len);
                if (cnt_q == fetch_len) state_nx = S_LAUNCH;
            end
            S_LAUNCH: begin
                core_start = 1'b1;
                state_nx   = S_WAIT;
            end
            S_WAIT:   if (done_rise) state_nx = S_WRITE;
            S_WRITE: begin
                edge_we  = 1'b1;
                state_nx = last_win ? S_FIN : S_FETCH;
            end
            S_FIN:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            eaddr_q   <= '0;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            rd_slot_q <= '0;
            done_q    <= 1'b0;
            z_q       <= '0;
            for (int k = 0; k < 9; k++) win[k] <= '0;
        end else begin
            state     <= state_nx;
            done_q    <= bus.core_done;
            rd_q      <= src_rd;
            rd_slot_q <= rd_slot;
            if (rd_q) win[rd_slot_q] <= bus.src_rdata;
            case (state)
                S_IDLE: if (frame_start) begin
                    i_q     <= ONE_A;
                    j_q     <= ONE_A;
                    eaddr_q <= '0;
                    cnt_q   <= '0;
                end
                S_FETCH: begin
                    cnt_q <= cnt_q + 4'd1;
`ifdef SEQ_WINDOW_REUSE_EN
                    if (cnt_q == 4'd0 && j_q != ONE_A) begin
                        for (int r = 0; r < 3; r++) begin
                            win[r*3]   <= win[r*3+1];
                            win[r*3+1] <= win[r*3+2];
                        end
                    end
`endif
                end
                S_WAIT: if (done_rise) z_q <= bus.core_z;
                S_WRITE: begin
                    eaddr_q <= eaddr_q + ONE_A;
                    cnt_q   <= '0;
                    if (j_q == LAST_J) begin
                        j_q <= ONE_A;
                        i_q <= i_q + ONE_A;
                    end else begin
                        j_q <= j_q + ONE_A;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy           = (state != S_IDLE);
    assign frame_done     = (state == S_FIN);
    assign dbg_state      = state;
    assign bus.src_rd     = src_rd;
    assign bus.src_addr   = src_rd ? rd_addr : '0;
    assign bus.core_start = core_start;
    assign bus.edge_we    = edge_we;
    assign bus.edge_addr  = edge_we ? eaddr_q : '0;
    assign bus.edge_wdata = edge_we ? z_q : '0;
    assign bus.pixel_1_bin = win[0];
    assign bus.pixel_2_bin = win[1];
    assign bus.pixel_3_bin = win[2];
    assign bus.pixel_4_bin = win[3];
    assign bus.pixel_6_bin = win[5];
    assign bus.pixel_7_bin = win[6];
    assign bus.pixel_8_bin = win[7];
    assign bus.pixel_9_bin = win[8];
endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Bench for sobel_frame_sequencer on a 4x5 image: memory and core responders,
// a window-level reference model and a per-cycle compare process.
module tb_sobel_frame_sequencer;
    localparam int ROWS = 4;
    localparam int COLS = 5;
    localparam int AW   = 20;
    localparam int NWIN = (ROWS - 2) * (COLS - 2);
    localparam int NPIX = ROWS * COLS;
`ifdef SEQ_WINDOW_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       busy, frame_done;
    logic [2:0] dbg_state;

    sobel_frame_sequencer_if #(.ADDR_W(AW)) bus ();

    sobel_frame_sequencer #(.SRC_ROWS(ROWS), .SRC_COLS(COLS), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .busy(busy),
        .frame_done(frame_done), .dbg_state(dbg_state), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0]    img [NPIX];
    logic [7:0]    z_tab [NWIN];
    logic [AW+7:0] exp_q[$];
    logic [AW-1:0] exp_rd_q[$];
    logic [AW-1:0] rd_log[$];
    logic [AW+7:0] wr_log[$];
    logic [7:0]    pix [9];
    int  cur_win = 0, latency = 10, hold_cfg = 2, lat_left = 0, hold_left = 0;
    int  fd_cnt = 0, last_start_win = -1;
    bit  exp_busy = 0, exp_fd = 0, pend = 0, glitch_en = 0, glitched = 0;
    bit  log_en = 0, chk_zero = 0, rd_pend = 0;
    logic [7:0] rd_data = '0;

    assign pix[0] = bus.pixel_1_bin;
    assign pix[1] = bus.pixel_2_bin;
    assign pix[2] = bus.pixel_3_bin;
    assign pix[3] = bus.pixel_4_bin;
    assign pix[4] = 8'h00;
    assign pix[5] = bus.pixel_6_bin;
    assign pix[6] = bus.pixel_7_bin;
    assign pix[7] = bus.pixel_8_bin;
    assign pix[8] = bus.pixel_9_bin;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Source address of neighbour k (row-major 0..8) of window w.
    function automatic int px_addr(int w, int k);
        int i = 1 + w / (COLS - 2);
        int j = 1 + w % (COLS - 2);
        return (i - 1 + k / 3) * COLS + (j - 1 + k % 3);
    endfunction

    function automatic void load_reads(int w);
        int j = 1 + w % (COLS - 2);
        exp_rd_q.delete();
        if (REUSE && j > 1) begin
            for (int r = 0; r < 3; r++) exp_rd_q.push_back(AW'(px_addr(w, r * 3 + 2)));
        end else begin
            for (int k = 0; k < 9; k++)
                if (k != 4 || REUSE) exp_rd_q.push_back(AW'(px_addr(w, k)));
        end
    endfunction

    task automatic check_pix(input string name);
        for (int k = 0; k < 9; k++)
            if (k != 4) check(name, pix[k], img[px_addr(cur_win, k)]);
    endtask

    // Responder and compare process; runs at the falling edge, inputs change there too.
    initial begin
        bus.src_rdata = '0;
        bus.core_done = 1'b0;
        bus.core_z    = '0;
        forever begin
            @(negedge clk);
            if (chk_zero) begin
                check("reset_ctrl", {busy, frame_done, bus.src_rd, bus.core_start, bus.edge_we}, '0);
                check("reset_addr", {bus.src_addr, bus.edge_addr, bus.edge_wdata}, '0);
                check("reset_pix", {bus.pixel_1_bin, bus.pixel_2_bin, bus.pixel_3_bin, bus.pixel_4_bin,
                                    bus.pixel_6_bin, bus.pixel_7_bin, bus.pixel_8_bin, bus.pixel_9_bin}, '0);
            end
            chk_zero = reset;
            if (reset) begin
                exp_busy = 0; exp_fd = 0; pend = 0; hold_left = 0; rd_pend = 0;
                exp_q.delete(); exp_rd_q.delete();
                bus.core_done = 1'b0;
            end else begin
                bit nb, nfd;
                check("busy", busy, exp_busy);
                check("frame_done", frame_done, exp_fd);
                nb = exp_busy;
                nfd = 0;
                if (exp_fd) nb = 0;
                if (frame_done) fd_cnt++;
                if (frame_start && !exp_busy) begin
                    nb = 1; cur_win = 0; glitched = 0;
                    exp_q.delete();
                    load_reads(0);
                end
                if (bus.src_rd) begin
                    check("src_rd_expected", exp_rd_q.size() > 0, 1);
                    if (exp_rd_q.size() > 0) check("src_addr", bus.src_addr, exp_rd_q.pop_front());
                    if (log_en && cur_win == 1) rd_log.push_back(bus.src_addr);
                end
                if (bus.core_start) begin
                    check("reads_complete", exp_rd_q.size(), 0);
                    check_pix("pix_at_start");
                    last_start_win = cur_win;
                end
                if (bus.edge_we) begin
                    check_pix("pix_at_write");
                    check("edge_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("edge_write", {bus.edge_addr, bus.edge_wdata}, exp_q.pop_front());
                    if (log_en) wr_log.push_back({bus.edge_addr, bus.edge_wdata});
                    cur_win++;
                    glitched = 0;
                    if (cur_win == NWIN) nfd = 1;
                    else load_reads(cur_win);
                end
                exp_busy = nb;
                exp_fd = nfd;
                // Core: result rises after the configured latency, once any held level has dropped.
                if (bus.core_done) begin
                    if (hold_left == 0) bus.core_done = 1'b0;
                    else hold_left--;
                end else if (pend) begin
                    if (lat_left > 0) lat_left--;
                    else begin
                        bus.core_done = 1'b1;
                        bus.core_z = z_tab[cur_win];
                        hold_left = hold_cfg;
                        pend = 0;
                        exp_q.push_back({AW'(cur_win), z_tab[cur_win]});
                    end
                end else if (glitch_en && !glitched && bus.src_rd) begin
                    bus.core_done = 1'b1;
                    bus.core_z = 8'hEE;
                    hold_left = 0;
                    glitched = 1;
                end
                if (bus.core_start) begin
                    pend = 1;
                    lat_left = latency;
                end
                bus.src_rdata = rd_pend ? rd_data : 8'($urandom);
                rd_pend = bus.src_rd;
                rd_data = (int'(bus.src_addr) < NPIX) ? img[bus.src_addr] : 8'h00;
            end
        end
    end

    task automatic new_image(input bit z_is_index);
        for (int k = 0; k < NPIX; k++) img[k] = 8'($urandom);
        for (int w = 0; w < NWIN; w++) z_tab[w] = z_is_index ? 8'(w) : 8'($urandom);
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 frame_start = 1'b1;
        @(posedge clk); #2 frame_start = 1'b0;
    endtask

    task automatic wait_frame(input bit spam);
        int start = fd_cnt;
        int n = 0;
        while (n < 4000) begin
            @(posedge clk); #2;
            if (fd_cnt != start) break;
            frame_start = spam && ($urandom_range(0, 5) == 0);
            n++;
        end
        frame_start = 1'b0;
        check("frame_completes", fd_cnt != start, 1);
    endtask

    task automatic run_frame(input bit spam);
        pulse_start();
        wait_frame(spam);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int exp_rd1[$];
        int n;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);

        // Window index as core result; log reads and writes for literal pins.
        new_image(1); latency = 10; hold_cfg = 2; log_en = 1;
        run_frame(0);
        log_en = 0;
        if (REUSE) exp_rd1 = '{3, 8, 13};
        else exp_rd1 = '{1, 2, 3, 6, 8, 11, 12, 13};
        check("win1_read_count", rd_log.size(), exp_rd1.size());
        for (int k = 0; k < rd_log.size() && k < exp_rd1.size(); k++)
            check("win1_read_addr", rd_log[k], exp_rd1[k]);
        check("write_count", wr_log.size(), 6);
        for (int k = 0; k < wr_log.size() && k < 6; k++)
            check("write_literal", wr_log[k], {AW'(k), 8'(k)});

        // Random results and latencies, frame_start spam while busy.
        for (int f = 0; f < 3; f++) begin
            new_image(0); latency = $urandom_range(0, 12); hold_cfg = $urandom_range(0, 4);
            run_frame(1);
        end

        // core_done held high for 50 cycles after every result.
        new_image(0); latency = 3; hold_cfg = 50;
        run_frame(1);
        repeat (60) @(posedge clk);

        // Spurious core_done pulse during each FETCH.
        new_image(0); latency = 4; hold_cfg = 1; glitch_en = 1;
        run_frame(0);
        glitch_en = 0;

        // Reset while waiting on window 2, then a fresh frame from address 0.
        new_image(0); latency = 10; hold_cfg = 1; last_start_win = -1;
        pulse_start();
        n = 0;
        while (last_start_win != 2 && n < 4000) begin @(posedge clk); n++; end
        check("reached_window2", last_start_win, 2);
        #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        repeat (30) @(posedge clk);
        wr_log.delete(); log_en = 1;
        new_image(1);
        run_frame(0);
        log_en = 0;
        check("restart_write_count", wr_log.size(), 6);
        if (wr_log.size() > 0) check("restart_first_write", wr_log[0], {AW'(0), 8'h00});

        new_image(0); latency = $urandom_range(0, 6); hold_cfg = 0;
        run_frame(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
